// File: rtl/ahb_bus_arbiter_pkg.sv
// ahb_arb_pkg: AHB transfer types and arbiter FSM encoding shared by the arbiter slice
package ahb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} HTRANS_state;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_OWN, ARB_HANDOVER} arb_state_t;
  localparam int ARB_N_MASTERS = 3;
  localparam int ARB_IDX_W = $clog2(ARB_N_MASTERS);
  function automatic logic is_beat(input logic [1:0] t);
    return t == NONSEQ || t == SEQ;
  endfunction
endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_arb_if: per-master request/grant bundle between bus masters and the arbiter
interface ahb_arb_if import ahb_arb_pkg::*; #(
  parameter int N_MASTERS = ARB_N_MASTERS,
  parameter int IDX_W = $clog2(N_MASTERS)
) ();
  logic [N_MASTERS-1:0][1:0] i_HTRANS;
  logic [N_MASTERS-1:0]      i_slave_done;
  logic                      i_urgent;
  logic [N_MASTERS-1:0]      o_HREADY;
  logic [IDX_W-1:0]          o_HMASTER;
  logic                      o_bus_busy;
  logic                      o_preempt;
  modport slave (input i_HTRANS, i_slave_done, i_urgent,
                 output o_HREADY, o_HMASTER, o_bus_busy, o_preempt);
  modport master (output i_HTRANS, i_slave_done, i_urgent,
                  input o_HREADY, o_HMASTER, o_bus_busy, o_preempt);
endinterface

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// rr_picker: round-robin winner search starting after last_owner, with urgent override
module rr_picker import ahb_arb_pkg::*; #(
  parameter int N_MASTERS = ARB_N_MASTERS,
  parameter int IDX_W = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last_owner,
  input  logic                 urgent,
  input  logic [IDX_W-1:0]     prio_idx,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx = '0;
    winner = '0;
    valid = |req;
    // scan farthest first so the nearest requester after last_owner wins
    for (int i = N_MASTERS; i >= 1; i--) begin
      idx = IDX_W'((int'(last_owner) + i) % N_MASTERS);
      if (req[idx]) winner = idx;
    end
    if (urgent && req[prio_idx]) winner = prio_idx;
  end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-Lite path arbiter with hold limit and read-DMA urgency
module ahb_bus_arbiter import ahb_arb_pkg::*; #(
  parameter int N_MASTERS = ARB_N_MASTERS,
  parameter int MAX_HOLD = 16,
  parameter int RD_PRIO_IDX = 0
) (
  input logic   HCLK,
  input logic   HRESET,
  ahb_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] hmaster_q, hmaster_d, last_owner_q, last_owner_d, winner;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [N_MASTERS-1:0] req, owner_oh, hready_q, hready_d;
  logic valid, busy_q, busy_d, preempt_q, preempt_d;
  logic done_rel, idle_rel, at_max, contend, preempt_rel, release_own;
  HTRANS_state owner_tr;
  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) req[m] = HTRANS_state'(bus.i_HTRANS[m]) == NONSEQ;
  end
  rr_picker #(.N_MASTERS(N_MASTERS), .IDX_W(IDX_W)) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .urgent     (bus.i_urgent),
    .prio_idx   (IDX_W'(RD_PRIO_IDX)),
    .winner     (winner),
    .valid      (valid)
  );
  // slave_done outranks idle, which outranks preemption, so o_preempt only flags forced releases
  always_comb begin
    owner_oh = N_MASTERS'(1) << hmaster_q;
    owner_tr = HTRANS_state'(bus.i_HTRANS[hmaster_q]);
    done_rel = bus.i_slave_done[hmaster_q];
    idle_rel = owner_tr == IDLE;
    at_max = beat_cnt_q == CNT_W'(MAX_HOLD);
    contend = |(req & ~owner_oh) ||
              (bus.i_urgent && req[RD_PRIO_IDX] && hmaster_q != IDX_W'(RD_PRIO_IDX));
    preempt_rel = at_max && contend && !done_rel && !idle_rel;
    release_own = done_rel || idle_rel || preempt_rel;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  state_d = valid ? ARB_GRANT : ARB_IDLE;
      ARB_GRANT: state_d = ARB_OWN;
      ARB_OWN:   state_d = release_own ? ARB_HANDOVER : ARB_OWN;
      default:   state_d = ARB_IDLE;
    endcase
  end
  always_comb begin
    hmaster_d = (state_q == ARB_IDLE && valid) ? winner : hmaster_q;
    last_owner_d = (state_q == ARB_OWN && release_own) ? hmaster_q : last_owner_q;
    beat_cnt_d = (state_q == ARB_GRANT) ? '0 :
                 (state_q == ARB_OWN && is_beat(owner_tr) && !at_max) ? beat_cnt_q + CNT_W'(1) :
                 beat_cnt_q;
    hready_d = (state_d == ARB_OWN) ? owner_oh : '0;
    busy_d = state_d == ARB_GRANT || state_d == ARB_OWN;
    preempt_d = state_q == ARB_OWN && preempt_rel;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hmaster_q    <= '0;
      last_owner_q <= IDX_W'(N_MASTERS - 1);
      beat_cnt_q   <= '0;
      hready_q     <= '0;
      busy_q       <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      hmaster_q    <= hmaster_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      hready_q     <= hready_d;
      busy_q       <= busy_d;
      preempt_q    <= preempt_d;
    end
  end
  assign bus.o_HREADY   = hready_q;
  assign bus.o_HMASTER  = hmaster_q;
  assign bus.o_bus_busy = busy_q;
  assign bus.o_preempt  = preempt_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed cycle-exact checks of grant order, preemption, urgency and reset
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  ahb_arb_if #(.N_MASTERS(3)) bus ();
  ahb_bus_arbiter #(.N_MASTERS(3), .MAX_HOLD(16), .RD_PRIO_IDX(0)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge HCLK) if (chk_on) check("onehot0_hready", 32'($onehot0(bus.o_HREADY)), 32'd1);
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic drive(input int m, input HTRANS_state t);
    bus.i_HTRANS[m] = t;
  endtask
  task automatic do_reset();
    HRESET = 1'b1;
    bus.i_HTRANS = '0;
    bus.i_slave_done = '0;
    bus.i_urgent = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    check("rst_hready", 32'(bus.o_HREADY), 32'd0);
    check("rst_hmaster", 32'(bus.o_HMASTER), 32'd0);
    check("rst_busy", 32'(bus.o_bus_busy), 32'd0);
    check("rst_preempt", 32'(bus.o_preempt), 32'd0);
    HRESET = 1'b0;
  endtask
  task automatic expect_grant(input int m, input int lat);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("pre_grant_hready", 32'(bus.o_HREADY), 32'd0);
    end
    check("grant_busy_early", 32'(bus.o_bus_busy), 32'd1);
    tick();
    check("grant_hready", 32'(bus.o_HREADY), 32'(1 << m));
    check("grant_hmaster", 32'(bus.o_HMASTER), 32'(m));
    check("grant_busy", 32'(bus.o_bus_busy), 32'd1);
  endtask
  task automatic serve(input int m, input int beats);
    for (int i = 1; i < beats; i++) begin
      tick();
      drive(m, SEQ);
      check("serve_hready", 32'(bus.o_HREADY), 32'(1 << m));
    end
    bus.i_slave_done[m] = 1'b1;
    tick();
    check("handover_hready", 32'(bus.o_HREADY), 32'd0);
    check("handover_preempt", 32'(bus.o_preempt), 32'd0);
    check("handover_busy", 32'(bus.o_bus_busy), 32'd0);
    bus.i_slave_done[m] = 1'b0;
    drive(m, IDLE);
  endtask
  initial begin
    // 1: single request, latency 2, then sole-requester re-grant
    do_reset();
    drive(1, NONSEQ);
    tick();
    check("t1_grant_state_hready", 32'(bus.o_HREADY), 32'd0);
    check("t1_grant_state_hmaster", 32'(bus.o_HMASTER), 32'd1);
    check("t1_grant_state_busy", 32'(bus.o_bus_busy), 32'd1);
    tick();
    check("t1_hready", 32'(bus.o_HREADY), 32'b010);
    check("t1_hmaster", 32'(bus.o_HMASTER), 32'd1);
    check("t1_busy", 32'(bus.o_bus_busy), 32'd1);
    bus.i_slave_done[1] = 1'b1;
    tick();
    check("t1_handover_hready", 32'(bus.o_HREADY), 32'd0);
    check("t1_handover_busy", 32'(bus.o_bus_busy), 32'd0);
    bus.i_slave_done[1] = 1'b0;
    expect_grant(1, 3);
    drive(1, IDLE);
    tick();
    check("t1_release_hready", 32'(bus.o_HREADY), 32'd0);
    check("t1_hmaster_held", 32'(bus.o_HMASTER), 32'd1);
    // 2: three-way tie served 0,1,2
    do_reset();
    for (int m = 0; m < 3; m++) drive(m, NONSEQ);
    expect_grant(0, 2);
    serve(0, 4);
    expect_grant(1, 3);
    serve(1, 4);
    expect_grant(2, 3);
    serve(2, 4);
    tick();
    tick();
    check("t2_idle_hready", 32'(bus.o_HREADY), 32'd0);
    check("t2_idle_busy", 32'(bus.o_bus_busy), 32'd0);
    // 3: hold limit preemption, then no preemption without contention
    do_reset();
    drive(2, NONSEQ);
    expect_grant(2, 2);
    drive(2, SEQ);
    drive(1, NONSEQ);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t3_hold_hready", 32'(bus.o_HREADY), 32'b100);
      check("t3_hold_preempt", 32'(bus.o_preempt), 32'd0);
    end
    tick();
    check("t3_preempt", 32'(bus.o_preempt), 32'd1);
    check("t3_preempt_hready", 32'(bus.o_HREADY), 32'd0);
    drive(2, NONSEQ);
    tick();
    check("t3_preempt_pulse", 32'(bus.o_preempt), 32'd0);
    check("t3_idle_hready", 32'(bus.o_HREADY), 32'd0);
    expect_grant(1, 2);
    drive(1, IDLE);
    tick();
    check("t3_m1_release", 32'(bus.o_HREADY), 32'd0);
    expect_grant(2, 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_sole_hready", 32'(bus.o_HREADY), 32'b100);
      check("t3_sole_preempt", 32'(bus.o_preempt), 32'd0);
    end
    drive(2, IDLE);
    tick();
    // 4: urgent override versus round-robin from last_owner=0
    do_reset();
    drive(0, NONSEQ);
    expect_grant(0, 2);
    drive(0, IDLE);
    tick();
    check("t4_handover", 32'(bus.o_HREADY), 32'd0);
    drive(0, NONSEQ);
    drive(1, NONSEQ);
    bus.i_urgent = 1'b1;
    expect_grant(0, 3);
    bus.i_urgent = 1'b0;
    bus.i_slave_done[0] = 1'b1;
    tick();
    check("t4_release", 32'(bus.o_HREADY), 32'd0);
    bus.i_slave_done[0] = 1'b0;
    expect_grant(1, 3);
    drive(0, IDLE);
    drive(1, IDLE);
    tick();
    // 5: slave_done coinciding with preemption, and non-owner slave_done
    do_reset();
    drive(2, NONSEQ);
    expect_grant(2, 2);
    drive(2, SEQ);
    drive(1, NONSEQ);
    for (int i = 1; i <= 16; i++) begin
      tick();
      bus.i_slave_done[1] = (i == 5);
      check("t5_hold_hready", 32'(bus.o_HREADY), 32'b100);
    end
    bus.i_slave_done[1] = 1'b0;
    bus.i_slave_done[2] = 1'b1;
    tick();
    check("t5_no_preempt", 32'(bus.o_preempt), 32'd0);
    check("t5_release_hready", 32'(bus.o_HREADY), 32'd0);
    bus.i_slave_done[2] = 1'b0;
    drive(2, IDLE);
    expect_grant(1, 3);
    // 6: reset while owned, then 3-way tie goes to master 0
    for (int m = 0; m < 3; m++) drive(m, NONSEQ);
    HRESET = 1'b1;
    tick();
    check("t6_rst_hready", 32'(bus.o_HREADY), 32'd0);
    check("t6_rst_busy", 32'(bus.o_bus_busy), 32'd0);
    check("t6_rst_hmaster", 32'(bus.o_HMASTER), 32'd0);
    check("t6_rst_preempt", 32'(bus.o_preempt), 32'd0);
    HRESET = 1'b0;
    expect_grant(0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
